control_fsm: RTL

CONTROL_FSM -- requirements
Module: control_fsm

---
 rtl/control_fsm_if.sv | 27 ++
 rtl/control_fsm.sv | 106 ++++++++++
 2 files changed

// File: rtl/control_fsm_if.sv
// Handshake and control bus for the multi-cycle accumulator control FSM.
interface control_fsm_if;
  logic [3:0] opcode;
  logic       mem_ready;
  logic       acc_zero;
  logic       pc_write, ir_write, mem_read, mem_write, iord;
  logic       acc_write, acc_src, aluout_write;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] pc_src;
  logic       halted, illegal;
  logic [3:0] state;

  modport master (
    output opcode, mem_ready, acc_zero,
    input  pc_write, ir_write, mem_read, mem_write, iord,
           acc_write, acc_src, aluout_write, alu_src_b, alu_op, pc_src,
           halted, illegal, state
  );

  modport slave (
    input  opcode, mem_ready, acc_zero,
    output pc_write, ir_write, mem_read, mem_write, iord,
           acc_write, acc_src, aluout_write, alu_src_b, alu_op, pc_src,
           halted, illegal, state
  );
endinterface

// File: rtl/control_fsm.sv
// Multi-cycle control FSM for a 4-bit-opcode accumulator CPU.
// Build option ILLEGAL_TRAP_EN: undefined opcodes halt instead of acting as NOPs.
module control_fsm (
  input  logic         clk,
  input  logic         reset,
  control_fsm_if.slave bus
);
  typedef enum logic [3:0] {
    FETCH  = 4'd0, DECODE = 4'd1, EXEC   = 4'd2, MEM_RD = 4'd3, MEM_WR = 4'd4,
    WB_ALU = 4'd5, BRANCH = 4'd6, JUMP   = 4'd7, HALT   = 4'd8, WB_MEM = 4'd9
  } state_t;

  state_t cur, nxt;
  logic   undef_op;

  assign undef_op = (bus.opcode >= 4'd9) && (bus.opcode <= 4'd14);

  always_ff @(posedge clk or posedge reset)
    if (reset) cur <= FETCH;
    else       cur <= nxt;

  always_comb begin
    nxt              = cur;
    bus.pc_write     = 1'b0;
    bus.ir_write     = 1'b0;
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    bus.iord         = 1'b0;
    bus.acc_write    = 1'b0;
    bus.acc_src      = 1'b0;
    bus.aluout_write = 1'b0;
    bus.alu_src_b    = 2'd0;
    bus.alu_op       = 3'd0;
    bus.pc_src       = 2'd0;
    bus.halted       = 1'b0;
    bus.illegal      = 1'b0;
    bus.state        = cur;
    case (cur)
      FETCH: begin
        bus.mem_read = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          nxt          = DECODE;
        end
      end
      DECODE: begin
        if (undef_op) begin
          bus.illegal = 1'b1;
`ifdef ILLEGAL_TRAP_EN
          nxt = HALT;
`else
          nxt = FETCH;
`endif
        end else begin
          case (bus.opcode)
            4'd4:    nxt = MEM_RD;
            4'd5:    nxt = MEM_WR;
            4'd7:    nxt = BRANCH;
            4'd8:    nxt = JUMP;
            4'd15:   nxt = HALT;
            default: nxt = EXEC;
          endcase
        end
      end
      EXEC: begin
        bus.aluout_write = 1'b1;
        // ADDI uses the immediate with ADD; register ops take the op from opcode[1:0]
        if (bus.opcode == 4'd6) bus.alu_src_b = 2'd1;
        else                    bus.alu_op    = {1'b0, bus.opcode[1:0]};
        nxt = WB_ALU;
      end
      WB_ALU: begin
        bus.acc_write = 1'b1;
        nxt           = FETCH;
      end
      MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
        if (bus.mem_ready) nxt = WB_MEM;
      end
      WB_MEM: begin
        bus.acc_write = 1'b1;
        bus.acc_src   = 1'b1;
        nxt           = FETCH;
      end
      MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
        if (bus.mem_ready) nxt = FETCH;
      end
      BRANCH: begin
        bus.pc_src   = 2'd1;
        bus.pc_write = bus.acc_zero;
        nxt          = FETCH;
      end
      JUMP: begin
        bus.pc_src   = 2'd2;
        bus.pc_write = 1'b1;
        nxt          = FETCH;
      end
      HALT: bus.halted = 1'b1;
      default: nxt = FETCH;
    endcase
  end
endmodule
